// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register file write ports
// among NUM_REQ requesters, with same-address collision avoidance and registered port drive.
module regfile_write_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_PORTS = 4,
  parameter int log2regs  = 3,
  parameter int size      = 32
) (
  input  logic                          CGRA_Clock,
  input  logic                          CGRA_Reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*log2regs-1:0]   req_addr,
  input  logic [NUM_REQ*size-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]          WE,
  output logic [NUM_PORTS*log2regs-1:0] address_in,
  output logic [NUM_PORTS*size-1:0]     in,
  output logic [15:0]                   conflict_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [15:0]                   conflict_count_q, conflict_count_d;
  logic [NUM_PORTS-1:0]          we_q, we_d;
  logic [NUM_PORTS*log2regs-1:0] addr_q, addr_d;
  logic [NUM_PORTS*size-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]            grant;
  logic                          deferred;

  always_comb begin
    int idx;
    int n_grant;
    logic clash;
    logic [log2regs-1:0] a;
    grant    = '0;
    we_d     = '0;
    addr_d   = '0;
    data_d   = '0;
    rr_ptr_d = rr_ptr_q;
    n_grant  = 0;
    idx      = 0;
    clash    = 1'b0;
    a        = '0;
    // Scan from rr_ptr; each grant claims the next free port and reserves its address.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      a = req_addr[idx*log2regs +: log2regs];
      clash = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j < n_grant && addr_d[j*log2regs +: log2regs] == a) clash = 1'b1;
      end
      if (req_valid[idx] && !hold && n_grant < NUM_PORTS && !clash) begin
        grant[idx] = 1'b1;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (j == n_grant) begin
            we_d[j]                         = 1'b1;
            addr_d[j*log2regs +: log2regs]  = a;
            data_d[j*size +: size]          = req_data[idx*size +: size];
          end
        end
        n_grant  = n_grant + 1;
        rr_ptr_d = (idx + 1 >= NUM_REQ) ? '0 : PTR_W'(idx + 1);
      end
    end
    deferred = !hold && (|(req_valid & ~grant));
    conflict_count_d = conflict_count_q;
    if (deferred && conflict_count_q != 16'hFFFF) conflict_count_d = conflict_count_q + 16'd1;
  end

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      rr_ptr_q         <= '0;
      conflict_count_q <= '0;
      we_q             <= '0;
      addr_q           <= '0;
      data_q           <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      conflict_count_q <= conflict_count_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
    end
  end

  // Ready is forced low during reset so nothing transfers while state is being cleared.
  assign req_ready      = CGRA_Reset ? '0 : grant;
  assign WE             = we_q;
  assign address_in     = addr_q;
  assign in             = data_q;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench for regfile_write_arbiter
// against a queue-based round-robin reference model.
module tb_regfile_write_arbiter;

  localparam int NR = 8;
  localparam int NP = 4;
  localparam int AW = 3;
  localparam int DW = 32;

  logic                CGRA_Clock = 1'b0;
  logic                CGRA_Reset = 1'b1;
  logic                hold = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR*AW-1:0]    req_addr = '0;
  logic [NR*DW-1:0]    req_data = '0;
  logic [NR-1:0]       req_ready;
  logic [NP-1:0]       WE;
  logic [NP*AW-1:0]    address_in;
  logic [NP*DW-1:0]    in;
  logic [15:0]         conflict_count;

  regfile_write_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .log2regs(AW), .size(DW)) dut (
    .CGRA_Clock(CGRA_Clock), .CGRA_Reset(CGRA_Reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .WE(WE), .address_in(address_in), .in(in),
    .conflict_count(conflict_count)
  );

  always #5 CGRA_Clock = ~CGRA_Clock;

  int n_vec = 0;
  int n_err = 0;

  // Requester-side view.
  bit        v_valid [NR];
  int        v_addr  [NR];
  logic [31:0] v_data [NR];
  bit        v_hold;

  // Model state and per-cycle expectations.
  int          m_rr, m_cnt;
  logic [NP-1:0] m_we;
  int          m_paddr [NP];
  logic [31:0] m_pdata [NP];
  logic [NR-1:0] e_grant;
  logic [NP-1:0] e_we;
  int          e_paddr [NP];
  logic [31:0] e_pdata [NP];
  int          e_rr;
  bit          e_def;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    hold = v_hold;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = v_valid[i];
      req_addr[i*AW +: AW] = AW'(v_addr[i]);
      req_data[i*DW +: DW] = v_data[i];
    end
  endtask

  task automatic model_eval();
    int used[$];
    int i;
    bit hit;
    e_grant = '0; e_we = '0; e_rr = m_rr; e_def = 0;
    for (int p = 0; p < NP; p++) begin e_paddr[p] = 0; e_pdata[p] = '0; end
    for (int k = 0; k < NR; k++) begin
      i = (m_rr + k) % NR;
      if (!v_valid[i]) continue;
      hit = 0;
      foreach (used[u]) if (used[u] == v_addr[i]) hit = 1;
      if (v_hold || used.size() >= NP || hit) begin
        if (!v_hold) e_def = 1;
        continue;
      end
      e_we[used.size()] = 1'b1;
      e_paddr[used.size()] = v_addr[i];
      e_pdata[used.size()] = v_data[i];
      used.push_back(v_addr[i]);
      e_grant[i] = 1'b1;
      e_rr = (i + 1) % NR;
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; m_we = '0;
    for (int p = 0; p < NP; p++) begin m_paddr[p] = 0; m_pdata[p] = '0; end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_we"}, 32'(WE), 32'(m_we));
    for (int p = 0; p < NP; p++) begin
      check_eq({tag, "_addr"}, 32'(address_in[p*AW +: AW]), 32'(m_paddr[p]));
      check_eq({tag, "_data"}, in[p*DW +: DW], m_pdata[p]);
    end
    check_eq({tag, "_cnt"}, 32'(conflict_count), 32'(m_cnt));
  endtask

  // Called at posedge+1: applies inputs, checks ready mid-cycle, advances one edge,
  // consumes granted requests, then checks the registered outputs.
  task automatic cycle(input string tag, input bit chk);
    drive();
    model_eval();
    #3;
    if (chk) check_eq({tag, "_ready"}, 32'(req_ready), 32'(e_grant));
    @(posedge CGRA_Clock);
    m_we = e_we; m_rr = e_rr;
    for (int p = 0; p < NP; p++) begin m_paddr[p] = e_paddr[p]; m_pdata[p] = e_pdata[p]; end
    if (e_def && m_cnt < 16'hFFFF) m_cnt++;
    for (int i = 0; i < NR; i++) if (e_grant[i]) v_valid[i] = 0;
    #1;
    if (chk) check_outputs(tag);
  endtask

  task automatic clear_reqs();
    v_hold = 0;
    for (int i = 0; i < NR; i++) begin v_valid[i] = 0; v_addr[i] = 0; v_data[i] = '0; end
  endtask

  task automatic do_reset();
    CGRA_Reset = 1'b1;
    clear_reqs();
    v_valid[0] = 1; v_addr[0] = 5;
    drive();
    model_reset();
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_outputs("rst");
    @(posedge CGRA_Clock);
    #1;
    CGRA_Reset = 1'b0;
    clear_reqs();
    drive();
  endtask

  initial begin
    do_reset();
    for (int c = 0; c < 10; c++) cycle("idle", 1);

    // Three distinct writes fill ports 0..2.
    do_reset();
    v_valid[0] = 1; v_addr[0] = 1; v_data[0] = 32'hA;
    v_valid[1] = 1; v_addr[1] = 2; v_data[1] = 32'hB;
    v_valid[2] = 1; v_addr[2] = 3; v_data[2] = 32'hC;
    cycle("three", 1);
    check_eq("three_we_k", 32'(WE), 32'h7);
    check_eq("three_p2", in[2*DW +: DW], 32'hC);
    v_valid[3] = 1; v_addr[3] = 0; v_valid[4] = 1; v_addr[4] = 0;
    cycle("three_rr", 1);
    check_eq("three_rr_we", 32'(WE), 32'h1);
    check_eq("three_rr_data", 32'(address_in[0 +: AW]), 32'h0);

    // All eight distinct: two rounds of four.
    do_reset();
    for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = i; v_data[i] = 32'h100 + i; end
    cycle("all8a", 1);
    check_eq("all8a_cnt_k", 32'(conflict_count), 32'd1);
    cycle("all8b", 1);
    check_eq("all8b_cnt_k", 32'(conflict_count), 32'd1);
    check_eq("all8b_p3", in[3*DW +: DW], 32'h107);

    // Same address on requesters 2 and 5.
    do_reset();
    v_valid[2] = 1; v_addr[2] = 4; v_data[2] = 32'h22;
    v_valid[5] = 1; v_addr[5] = 4; v_data[5] = 32'h55;
    cycle("clash1", 1);
    check_eq("clash1_p0", in[0 +: DW], 32'h22);
    cycle("clash2", 1);
    check_eq("clash2_p0", in[0 +: DW], 32'h55);
    check_eq("clash2_cnt_k", 32'(conflict_count), 32'd1);

    // Everyone targets address 6: one grant per cycle in order.
    do_reset();
    for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = 6; v_data[i] = 32'h600 + i; end
    for (int c = 0; c < NR; c++) begin
      cycle("same6", 1);
      check_eq("same6_order", in[0 +: DW], 32'h600 + c);
    end
    check_eq("same6_cnt_k", 32'(conflict_count), 32'd7);

    // Hold freezes grants and counters.
    do_reset();
    for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = i; v_data[i] = $urandom; end
    cycle("pre_hold", 1);
    v_hold = 1;
    cycle("hold", 1);
    check_eq("hold_we_k", 32'(WE), 32'h0);
    check_eq("hold_cnt_k", 32'(conflict_count), 32'd1);
    v_hold = 0;
    cycle("post_hold", 1);
    check_eq("post_hold_addr0", 32'(address_in[0 +: AW]), 32'd4);

    // Random traffic with stable-until-ready requesters.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v_valid[i] && $urandom_range(0, 1) == 1) begin
          v_valid[i] = 1; v_addr[i] = $urandom_range(0, 7); v_data[i] = $urandom;
        end
      end
      v_hold = ($urandom_range(0, 9) == 0);
      cycle("rand", 1);
    end

    // Saturate the conflict counter.
    v_hold = 0;
    for (int c = 0; c < 65540; c++) begin
      for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = 2; end
      cycle("sat", 0);
    end
    check_eq("sat_cnt_k", 32'(conflict_count), 32'hFFFF);
    cycle("sat_more", 1);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = i; v_data[i] = $urandom; end
    cycle("burst", 1);
    check_eq("burst_we_k", 32'(WE), 32'hF);
    #1;
    CGRA_Reset = 1'b1;
    #1;
    check_eq("async_we", 32'(WE), 32'h0);
    check_eq("async_addr", 32'(address_in), 32'h0);
    check_eq("async_in0", in[0 +: DW], 32'h0);
    check_eq("async_ready", 32'(req_ready), 32'h0);
    check_eq("async_cnt", 32'(conflict_count), 32'h0);
    do_reset();
    for (int i = 0; i < NR; i++) begin v_valid[i] = 1; v_addr[i] = i; v_data[i] = $urandom; end
    cycle("after_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the 4 write ports of the 8-entry, 32-bit multi-port register file among NUM_REQ independent write requesters.
- Uses a valid/ready handshake per requester and round-robin priority.
- Prevents same-address collisions within one cycle.
- Drives the register file's WE/address_in/in ports from registers; sits directly in front of the register file inside the processing element.

Parameters:
NUM_REQ, 8, number of write requesters (2..16)
NUM_PORTS, 4, register file write ports driven
log2regs, 3, register address width
size, 32, data width

Ports:
CGRA_Clock  input  1  clock, all state on rising edge
CGRA_Reset  input  1  asynchronous, active-high reset
hold  input  1  when 1, no grants are issued this cycle
req_valid  input  NUM_REQ  requester i has a write pending
req_addr  input  NUM_REQ*log2regs  target register of requester i (slice i)
req_data  input  NUM_REQ*size  write data of requester i (slice i)
req_ready  output  NUM_REQ  combinational grant; transfer when valid&ready
WE  output  NUM_PORTS  registered write enable to register file port k
address_in  output  NUM_PORTS*log2regs  registered write address, port k
in  output  NUM_PORTS*size  registered write data, port k
conflict_count  output  16  saturating count of cycles with a deferred request

Behaviour:
- Reset (async, immediate):
  - WE=0, address_in=0, in=0.
  - rr_ptr=0, conflict_count=0.
  - req_ready is 0 while CGRA_Reset is high.
- Grant selection (combinational, each cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ; visit each requester exactly once.
  - Requester i is granted iff all of the following hold:
    - req_valid[i]=1
    - hold=0
    - fewer than NUM_PORTS grants already made this cycle
    - req_addr[i] differs from the address of every requester already granted this cycle
  - A valid but ungranted requester is "deferred". The cause is either port exhaustion or address conflict.
- Handshake:
  - req_ready[i] = grant[i].
  - req_ready may depend on req_valid and req_addr of all requesters, but never on WE/in.
  - Requesters must hold valid/addr/data stable until ready.
  - req_ready for an invalid requester is 0.
- Port assignment:
  - The j-th grant in scan order (j=0..) goes to port j.
  - On the next rising edge, WE[j]<=1, address_in[j]<=req_addr, in[j]<=req_data.
  - Ports with no grant: WE<=0; address_in/in<=0.
- Latency:
  - Handshake in cycle N → WE asserted during cycle N+1.
  - The register file captures the data at the end of N+1.
  - No two WE bits ever carry equal addresses in the same cycle, so the register file's port ordering never matters.
- rr_ptr update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Guarantees every persistently valid requester is granted within ceil(NUM_REQ/1) cycles, even when all requesters target one address.
- hold=1:
  - No grants; all WE<=0 next edge.
  - rr_ptr and conflict_count are unchanged; hold cycles do not count as conflicts.
- conflict_count:
  - Increments by 1 on each edge where hold=0 and at least one requester is deferred.
  - Saturates at 16'hFFFF.
- Reset mid-operation:
  - Pending grants are discarded; in-flight registered writes are cleared (WE=0) immediately.
  - Requesters see ready=0 and must re-present after reset release.
- NUM_REQ <= NUM_PORTS with distinct addresses: every valid requester is granted each cycle.

Test Plan:
- Reset released, req_valid=0 → WE=0, address_in=0, in=0, conflict_count=0 for 10 cycles; assert reset mid-burst → WE drops to 0 without a clock edge.
- Requesters 0,1,2 valid, addrs 1,2,3, data 0xA,0xB,0xC, rr_ptr=0 → ready=0b00000111; next cycle WE=0b0111, ports 0..2 = (1,0xA),(2,0xB),(3,0xC); rr_ptr=3.
- All 8 valid, distinct addrs 0..7, rr_ptr=0 → cycle 1 grants 0-3, cycle 2 grants 4-7; conflict_count=1 after cycle 1 and stays 1.
- Requesters 2 and 5 both addr 4, rr_ptr=0 → only req 2 granted, rr_ptr=3; next cycle req 5 granted; conflict_count=1; never two WE on addr 4 simultaneously.
- All 8 valid, all addr 6, held valid 8 cycles → exactly one grant per cycle in order 0,1,...,7; conflict_count=7.
- hold=1 with requesters valid → ready=0, WE=0 next cycle, rr_ptr and conflict_count unchanged; drop hold → grants resume from the same rr_ptr. Drive conflicts for 65540 cycles → conflict_count saturates at 0xFFFF.
